// File: rtl/button_debouncer.sv
// button_debouncer
//
// Conditions three raw push-button pins (prev, pause, next) for the
// song-selection controller. Each button is synchronised, debounced and turned
// into clean one-cycle press/release pulses. Buttons enabled in REPEAT_MASK
// also emit auto-repeat press pulses while held. All buttons share one clock
// and are otherwise fully independent.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   btn_raw[2:0] asynchronous bouncy pin levels, [0]=prev [1]=pause [2]=next
//   btn_level    debounced level
//   btn_press    one-cycle pulse on debounced rise, OR'd with auto-repeat pulses
//   btn_release  one-cycle pulse on debounced fall
//
// Repeat FSM (one per button)
//   state     | meaning
//   ST_IDLE   | button released, or repeat disabled for this button
//   ST_DELAY  | held; timing the initial delay up to the first repeat
//   ST_REPEAT | held; emitting a repeat pulse every REPEAT_PERIOD cycles

module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000,
  parameter logic [2:0]  REPEAT_MASK     = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_raw,
  output logic [2:0] btn_level,
  output logic [2:0] btn_press,
  output logic [2:0] btn_release
);

  localparam int unsigned RPT_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;

  // Guard the degenerate widths so a 1-bit counter is still declared.
  localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_W = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);
  localparam logic [DB_W-1:0]  DB_SAT      = '1;
  localparam logic [TMR_W-1:0] TMR_SAT     = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // Two-flop synchroniser; only sync_s2 is used downstream.
  logic [2:0] sync_s1;
  logic [2:0] sync_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= btn_raw;
      sync_s2 <= sync_s1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic [DB_W-1:0]  db_cnt;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    rpt_state_t       state;
    logic [TMR_W-1:0] timer;

    logic differs;
    logic flip;
    logic rise;
    logic fall;
    logic rpt_fire;

    assign differs = sync_s2[i] ^ level_q;
    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    assign flip    = differs && (db_cnt == DB_LAST);
    assign rise    = flip &  sync_s2[i];
    assign fall    = flip & ~sync_s2[i];

    // A debounced fall wins over a repeat that would land on the same cycle.
    assign rpt_fire = ~fall &
                      (((state == ST_DELAY)  && (timer == DELAY_LAST)) ||
                       ((state == ST_REPEAT) && (timer == PERIOD_LAST)));

    // Debounce counter, debounced level and registered edge pulses.
    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        if (!differs || flip) begin
          db_cnt <= '0;
        end else if (db_cnt != DB_SAT) begin
          db_cnt <= db_cnt + 1'b1;
        end

        if (flip) begin
          level_q <= sync_s2[i];
        end

        press_q   <= rise | rpt_fire;
        release_q <= fall;
      end
    end

    // Auto-repeat FSM. Masked-off buttons never leave ST_IDLE.
    always_ff @(posedge clk) begin
      if (rst) begin
        state <= ST_IDLE;
        timer <= '0;
      end else if (fall) begin
        state <= ST_IDLE;
        timer <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            timer <= '0;
            if (rise && REPEAT_MASK[i]) begin
              state <= ST_DELAY;
            end
          end

          ST_DELAY: begin
            if (timer == DELAY_LAST) begin
              timer <= '0;
              state <= ST_REPEAT;
            end else if (timer != TMR_SAT) begin
              timer <= timer + 1'b1;
            end
          end

          ST_REPEAT: begin
            if (timer == PERIOD_LAST) begin
              timer <= '0;
            end else if (timer != TMR_SAT) begin
              timer <= timer + 1'b1;
            end
          end

          default: begin
            state <= ST_IDLE;
            timer <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  localparam int         D    = 4;
  localparam int         RD   = 20;
  localparam int         RP   = 8;
  localparam logic [2:0] MASK = 3'b101;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_raw;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: pin delayed two edges, a level that follows it once it
  // has disagreed for D edges in a row, and repeat pulses placed arithmetically
  // at press_edge + RD + n*RP while the debounced level stays high.
  logic [2:0] m_s1, m_s2, m_level, m_press, m_release;
  int         m_run[3];
  int         m_press_edge[3];

  int first_press[3];
  int press_cnt[3];
  int rel_cnt[3];
  int last_rel[3];
  int pq2[$];

  task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input logic r, input logic [2:0] raw);
    m_press   = '0;
    m_release = '0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_level = '0;
      for (int i = 0; i < 3; i++) begin
        m_run[i] = 0;
        m_press_edge[i] = -1;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_run[i] = (m_s2[i] != m_level[i]) ? m_run[i] + 1 : 0;
        if (m_run[i] == D) begin
          m_run[i]   = 0;
          m_level[i] = m_s2[i];
          if (m_level[i]) begin
            m_press[i] = 1'b1;
            m_press_edge[i] = cyc;
          end else begin
            m_release[i] = 1'b1;
            m_press_edge[i] = -1;
          end
        end else if (MASK[i] && m_level[i] && m_press_edge[i] >= 0) begin
          int age;
          age = cyc - m_press_edge[i];
          if (age >= RD && ((age - RD) % RP) == 0) m_press[i] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      first_press[i] = -1;
      press_cnt[i]   = 0;
      rel_cnt[i]     = 0;
      last_rel[i]    = -1;
    end
    pq2.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(rst, btn_raw);
    #1;
    check3("level", btn_level, m_level);
    check3("press", btn_press, m_press);
    check3("release", btn_release, m_release);
    for (int i = 0; i < 3; i++) begin
      if (btn_press[i] === 1'b1) begin
        press_cnt[i]++;
        if (first_press[i] < 0) first_press[i] = cyc;
        if (i == 2) pq2.push_back(cyc);
      end
      if (btn_release[i] === 1'b1) begin
        rel_cnt[i]++;
        last_rel[i] = cyc;
      end
    end
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic wait_press(input int b, input int limit, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (btn_press[b] !== 1'b1 && waited < limit);
    check_int("wait_press_in_time", int'(btn_press[b] === 1'b1), 1);
  endtask

  initial begin
    int c;
    int w;
    int rem[3];
    logic [2:0] rv;

    rst = 1'b1;
    btn_raw = '0;
    m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0;
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0;
      m_press_edge[i] = -1;
    end
    clear_counts();

    // Reset state
    run(3);
    check3("reset_level", btn_level, 3'b000);
    check3("reset_press", btn_press, 3'b000);
    check3("reset_release", btn_release, 3'b000);
    rst = 1'b0;
    run(5);

    // Clean press on next with two auto-repeats inside a 40-cycle hold
    clear_counts();
    c = cyc;
    btn_raw[2] = 1'b1;
    run(40);
    check_int("clean_rise_latency", first_press[2] - (c + 1), 5);
    check_int("clean_press_count", press_cnt[2], 3);
    if (pq2.size() >= 3) begin
      check_int("clean_first_repeat", pq2[1] - pq2[0], RD);
      check_int("clean_second_repeat", pq2[2] - pq2[0], RD + RP);
    end
    btn_raw[2] = 1'b0;
    run(12);
    check_int("clean_release_count", rel_cnt[2], 1);

    // Bounce rejection on prev: 2-cycle toggles never reach D
    clear_counts();
    for (int t = 0; t < 10; t++) begin
      btn_raw[0] = ~btn_raw[0];
      run(2);
    end
    btn_raw[0] = 1'b0;
    run(12);
    check3("bounce_level", btn_level, 3'b000);
    check_int("bounce_press_count", press_cnt[0], 0);
    check_int("bounce_release_count", rel_cnt[0], 0);

    // Pause never repeats
    clear_counts();
    btn_raw[1] = 1'b1;
    run(100);
    c = cyc;
    btn_raw[1] = 1'b0;
    run(12);
    check_int("pause_press_count", press_cnt[1], 1);
    check_int("pause_release_count", rel_cnt[1], 1);
    check_int("pause_release_latency", last_rel[1] - (c + 1), 5);

    // Release during DELAY: fall lands exactly on the would-be first repeat
    clear_counts();
    btn_raw[0] = 1'b1;
    wait_press(0, 20, w);
    run(14);
    btn_raw[0] = 1'b0;
    run(12);
    check_int("delay_rel_press_count", press_cnt[0], 1);
    check_int("delay_rel_release_count", rel_cnt[0], 1);
    check_int("delay_rel_fall_offset", last_rel[0] - first_press[0], RD);

    // Simultaneous prev+next; prev must restart its delay from IDLE
    clear_counts();
    btn_raw = 3'b101;
    wait_press(0, 20, w);
    check3("simul_press", btn_press, 3'b101);
    run(25);
    check_int("simul_prev_count", press_cnt[0], 2);
    check_int("simul_next_count", press_cnt[2], 2);
    btn_raw = 3'b000;
    run(12);
    check_int("simul_release_prev", rel_cnt[0], 1);
    check_int("simul_release_next", rel_cnt[2], 1);

    // Reset while in REPEAT with next still held
    clear_counts();
    btn_raw[2] = 1'b1;
    wait_press(2, 20, w);
    run(25);
    rst = 1'b1;
    tick();
    check3("midrst_level", btn_level, 3'b000);
    check3("midrst_press", btn_press, 3'b000);
    check3("midrst_release", btn_release, 3'b000);
    rst = 1'b0;
    wait_press(2, 20, w);
    check_int("midrst_repress_latency", w, 6);
    btn_raw[2] = 1'b0;
    run(12);

    // Randomized runs of short glitches and long holds, occasional reset
    for (int i = 0; i < 3; i++) rem[i] = 0;
    rv = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0) begin
          rv[i]  = 1'($urandom_range(0, 1));
          rem[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6))
                                               : int'($urandom_range(10, 60));
        end
        rem[i]--;
      end
      btn_raw = rv;
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    btn_raw = '0;
    run(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions the three raw push-button inputs (prev, pause, next) before they reach the song-selection controller. Each button is synchronised, debounced, and reduced to clean single-cycle press/release pulses. Prev/next additionally auto-repeat while held, so the controller sees exactly one edge per intended action. Sits between the board pins and the controller's `button[2:0]` input.

## Interface
- `DEBOUNCE_CYCLES`, 2_000_000, cycles the synchronised input must differ from the stable state before the state flips (20 ms at 100 MHz); legal range ≥ 2.
- `REPEAT_DELAY`, 50_000_000, cycles from press pulse to first auto-repeat pulse.
- `REPEAT_PERIOD`, 10_000_000, cycles between subsequent auto-repeat pulses.
- `REPEAT_MASK`, 3'b101, per-button auto-repeat enable; bit 1 (pause) never repeats.
- `clk` in 1 system clock; single clock domain.
- `rst` in 1 reset, synchronous and active-high.
- `btn_raw` in 3 asynchronous, bouncy pin levels, active-high; [0]=prev, [1]=pause, [2]=next.
- `btn_level` out 3 debounced level.
- `btn_press` out 3 one-cycle pulse on debounced rising edge, OR'd with auto-repeat pulses.
- `btn_release` out 3 one-cycle pulse on debounced falling edge.

## Operation
- Per button, independent identical logic; there is no cross-button interaction.
- Synchroniser: two flops, `s1 <= btn_raw`, `s2 <= s1`; only `s2` is used downstream.
- Debounce counter: width `$clog2(DEBOUNCE_CYCLES)`.
  - If `s2 == btn_level`, counter ← 0.
  - Otherwise counter increments.
  - On the cycle the counter equals `DEBOUNCE_CYCLES-1` while still differing, `btn_level` ← `s2` next edge and counter ← 0.
  - Any bounce back to equality clears the counter; partial counts never carry over.
- Edge pulses: `btn_press`/`btn_release` are registered and assert in the same cycle `btn_level` first shows the new value. Each is high for exactly one cycle.
- Repeat FSM, per button with `REPEAT_MASK` bit set:
  - IDLE: entered on reset or when `btn_level` falls.
  - On a debounced rise, go to DELAY with timer ← 0.
  - DELAY: timer counts; at `REPEAT_DELAY-1`, emit a repeat pulse, timer ← 0, go to REPEAT.
  - REPEAT: at `REPEAT_PERIOD-1`, emit a repeat pulse, timer ← 0, stay in REPEAT.
  - Any state returns to IDLE on a debounced fall, same cycle the release pulse is produced; no repeat pulse is emitted in that cycle.
- Timer width is sized for `max(REPEAT_DELAY, REPEAT_PERIOD)`. Counters saturate; they never wrap.
- Masked-off buttons stay in IDLE permanently and produce only press/release pulses.

## Timing
- Reset values:
  - `btn_level`=0, `btn_press`=0, `btn_release`=0.
  - Synchroniser flops 0, all counters 0, FSM IDLE.
  - A button held through reset produces a press pulse `2+DEBOUNCE_CYCLES` cycles after `rst` deasserts.
- Latency: raw edge sampled by `s1` at edge k with no further bounce means `btn_level`/pulse update at edge `k+1+DEBOUNCE_CYCLES`.
- Minimum debounced pulse width: `DEBOUNCE_CYCLES` cycles. Shorter raw glitches are fully rejected.
- First repeat: `REPEAT_DELAY` cycles after the press pulse. Subsequent repeats are `REPEAT_PERIOD` apart.
- Reset mid-debounce or mid-repeat: everything returns to reset values on the next edge; no pulse is emitted in the reset cycle or the following cycle.
- Simultaneous buttons: pulses may coincide across bits. The downstream controller is responsible for arbitration.

## Test plan
Directed benches use `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY=20`, `REPEAT_PERIOD=8`.
- Clean press: raise `btn_raw[2]` and hold 40 cycles → `btn_level[2]` rises 5 cycles after the first sampling edge; exactly one `btn_press[2]` pulse; repeat pulses 20 and 28 cycles after the press pulse.
- Bounce rejection: toggle `btn_raw[0]` high/low every 2 cycles for 20 cycles, then leave it low → `btn_level[0]` stays 0; no press or release pulses.
- Pause no-repeat: hold `btn_raw[1]` for 100 cycles, then release → one press pulse, zero repeats, one release pulse 5 cycles after the falling sample.
- Release during DELAY: hold `btn_raw[0]` for 15 cycles after the debounced rise, then drop it → no repeat pulse; `btn_release[0]` once; FSM back in IDLE.
- Simultaneous: raise `btn_raw[0]` and `btn_raw[2]` on the same edge → `btn_press` = 3'b101 in a single cycle.
- Reset mid-repeat: assert `rst` for 1 cycle while in REPEAT with the button still held → all outputs 0; press re-emitted 6 cycles after `rst` deasserts.
